ahb_bram_if: RTL and testbench

AHB-Lite slave front end for the on-chip block RAM (byte-write port A, registered-address read port B, one-cycle read latency). It decodes AHB-Lite address/data phases into RAM port signals, generates byte-lane write enables from HSIZE/HADDR, and returns read data and responses to the bus matrix. Illegal transfers get a two-cycle ERROR response.

---
 rtl/ahb_bram_if.sv | 144 ++++++++++++++
 tb/tb_ahb_bram_if.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_if.sv
// ahb_bram_if: AHB-Lite slave front end for a dual-port block RAM.
//   Port A: byte-write port, driven during the write data phase.
//   Port B: registered-address read port, one-cycle read latency.
//   Illegal transfers (bad size, misaligned, beyond MEM_WORDS) get a
//   two-cycle ERROR response and never touch the RAM.
// Optional feature macro: AHB_BRAM_RDREG_EN
//   defined   -> reads take one wait state and HRDATA comes from a register.
//   undefined -> zero-wait reads, HRDATA taken straight from BRAM_DOUTB.
module ahb_bram_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int MEM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [31:0]           BRAM_DINA,
    output logic [3:0]            BRAM_WEA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_DOUTB
);

    localparam logic [1:0] S_IDLE    = 2'd0;
`ifdef AHB_BRAM_RDREG_EN
    localparam logic [1:0] S_RD_WAIT = 2'd1;
`endif
    localparam logic [1:0] S_ERR1    = 2'd2;
    localparam logic [1:0] S_ERR2    = 2'd3;

    // Word count widened by one bit so MEM_WORDS == 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);

    logic [1:0]            state, state_nxt;
    logic                  accept, start, illegal;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            lane_mask;
    logic                  wr_pend, rd_pend;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [3:0]            wr_mask;

    // Address bits above the byte window and HTRANS[0] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign accept   = HSEL & HTRANS[1] & HREADY;
    // Only IDLE and ERR2 present HREADYOUT=1, so only they can start a transfer.
    assign start    = accept & ((state == S_IDLE) | (state == S_ERR2));
    assign word_idx = HADDR[ADDR_WIDTH+1:2];

    // Decode size/alignment/range legality and byte-lane mask of the address phase.
    always_comb begin
        lane_mask = 4'b0000;
        illegal   = ({1'b0, word_idx} >= MEM_LIMIT);
        case (HSIZE)
            3'd0: lane_mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                lane_mask = 4'b0011 << {HADDR[1], 1'b0};
                if (HADDR[0]) illegal = 1'b1;
            end
            3'd2: begin
                lane_mask = 4'b1111;
                if (HADDR[1:0] != 2'b00) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Response FSM: error pair, optional read wait, otherwise idle.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_ERR1: state_nxt = S_ERR2;
`ifdef AHB_BRAM_RDREG_EN
            S_RD_WAIT: state_nxt = S_IDLE;
`endif
            default: begin
                if (start && illegal)
                    state_nxt = S_ERR1;
`ifdef AHB_BRAM_RDREG_EN
                else if (start && !HWRITE)
                    state_nxt = S_RD_WAIT;
`endif
                else
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // State and address-phase capture; reset drops any pending write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            wr_idx  <= '0;
            wr_mask <= 4'b0000;
        end else begin
            state   <= state_nxt;
            wr_pend <= start & ~illegal & HWRITE;
            rd_pend <= start & ~illegal & ~HWRITE;
            if (start && !illegal && HWRITE) begin
                wr_idx  <= word_idx;
                wr_mask <= lane_mask;
            end
        end
    end

    assign HREADYOUT  = (state == S_IDLE) | (state == S_ERR2);
    assign HRESP      = (state == S_ERR1) | (state == S_ERR2);

    // Write port is live only in a legal write data phase.
    assign BRAM_ADDRA = wr_idx;
    assign BRAM_DINA  = HWDATA;
    assign BRAM_WEA   = wr_pend ? wr_mask : 4'b0000;

    // RAM registers the read address itself, so feed the bus address through.
    assign BRAM_ADDRB = word_idx;

`ifdef AHB_BRAM_RDREG_EN
    logic [31:0] hrdata_q;

    // Capture RAM output during the read wait cycle; hold until the next read.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            hrdata_q <= 32'h0;
        else if (rd_pend)
            hrdata_q <= BRAM_DOUTB;
    end

    assign HRDATA = hrdata_q;
`else
    assign HRDATA = rd_pend ? BRAM_DOUTB : 32'h0;
`endif

endmodule

// File: tb/tb_ahb_bram_if.sv
// tb_ahb_bram_if: directed plus random AHB traffic against ahb_bram_if with
// a behavioural RAM on the BRAM ports and a byte-level reference memory.
module tb_ahb_bram_if;

    localparam int AW = 12;
    localparam int MW = 1024;
`ifdef AHB_BRAM_RDREG_EN
    localparam bit RDREG = 1'b1;
`else
    localparam bit RDREG = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [1:0]    HTRANS = '0;
    logic [2:0]    HSIZE = '0;
    logic          HWRITE = 1'b0;
    logic [31:0]   HWDATA = '0;
    logic          HREADY;
    logic          HREADYOUT, HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] BRAM_ADDRA, BRAM_ADDRB;
    logic [31:0]   BRAM_DINA, BRAM_DOUTB;
    logic [3:0]    BRAM_WEA;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_bram_if #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .BRAM_ADDRA(BRAM_ADDRA), .BRAM_DINA(BRAM_DINA), .BRAM_WEA(BRAM_WEA),
        .BRAM_ADDRB(BRAM_ADDRB), .BRAM_DOUTB(BRAM_DOUTB)
    );

    // Behavioural block RAM: byte writes and read-address register on the
    // same edge, asynchronous array read afterwards (write-first).
    logic [31:0]   bram [0:(1<<AW)-1];
    logic [AW-1:0] addrb_q;
    bit            clr = 1'b1;

    always @(posedge HCLK) begin
        if (clr) begin
            for (int i = 0; i < (1<<AW); i++) bram[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (BRAM_WEA[i]) bram[BRAM_ADDRA][8*i +: 8] <= BRAM_DINA[8*i +: 8];
        end
        addrb_q <= BRAM_ADDRB;
    end
    assign BRAM_DOUTB = bram[addrb_q];

    typedef struct {
        bit          sel;
        logic [1:0]  tr;
        bit          w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
    } op_t;

    logic [31:0] ref_mem [0:MW-1];
    op_t         dp;
    op_t         idle_op;
    logic [31:0] last_rd;
    int          ntot = 0;
    int          nbad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_bad(input op_t o);
        if (o.sz > 3'd2) return 1'b1;
        if (o.sz == 3'd1 && o.a[0]) return 1'b1;
        if (o.sz == 3'd2 && o.a[1:0] != 2'b00) return 1'b1;
        return (int'(o.a[AW+1:2]) >= MW);
    endfunction

    function automatic logic [3:0] lanes(input op_t o);
        case (o.sz)
            3'd0:    return 4'b0001 << o.a[1:0];
            3'd1:    return o.a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic op_t mk(input bit w, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd);
        op_t o;
        o.sel = 1'b1; o.tr = 2'b10; o.w = w; o.a = a; o.sz = sz; o.wd = wd;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        int  k;
        k     = $urandom_range(0, 9);
        o.sel = (k != 0);
        o.tr  = (k == 1) ? 2'b01 : (k == 2) ? 2'b00 : {1'b1, 1'($urandom_range(0, 1))};
        o.w   = 1'($urandom_range(0, 1));
        o.sz  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        o.a   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 16'h3FFF))
                                            : 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
            if (o.sz == 3'd1) o.a[0] = 1'b0;
            if (o.sz == 3'd2) o.a[1:0] = 2'b00;
        end
        o.wd  = $urandom;
        return o;
    endfunction

    // Present nx in its address phase while dp runs its data phase; check
    // dp's data phase cycle by cycle and retire it into the reference memory.
    task automatic issue(input op_t nx);
        op_t        cur;
        bit         act, bad;
        int         waits, cyc, idx;
        logic [3:0] wexp, m;
        cur   = dp;
        act   = cur.sel && cur.tr[1];
        bad   = act && is_bad(cur);
        waits = bad ? 1 : (act && !cur.w && RDREG) ? 1 : 0;
        idx   = int'(cur.a[AW+1:2]);
        cyc   = 0;
        HSEL = nx.sel; HTRANS = nx.tr; HADDR = nx.a; HSIZE = nx.sz; HWRITE = nx.w;
        HWDATA = cur.wd;
        forever begin
            @(negedge HCLK);
            wexp = (act && !bad && cur.w && cyc == 0) ? lanes(cur) : 4'b0000;
            chk("wea", 32'(BRAM_WEA), 32'(wexp));
            if (wexp != 4'b0000) chk("addra", 32'(BRAM_ADDRA), 32'(idx));
            chk("hresp", 32'(HRESP), 32'(bad));
            chk("hready", 32'(HREADYOUT), 32'(cyc == waits));
            if (act && !bad && !cur.w && HREADYOUT)
                chk("hrdata", HRDATA, ref_mem[idx]);
            if (HREADYOUT || cyc >= 3) break;
            cyc++;
        end
        if (act && !bad && cur.w) begin
            m = lanes(cur);
            for (int i = 0; i < 4; i++)
                if (m[i]) ref_mem[idx][8*i +: 8] = cur.wd[8*i +: 8];
        end
        last_rd = HRDATA;
        @(posedge HCLK); #1;
        dp = nx;
    endtask

    initial begin
        idle_op = '{sel: 1'b0, tr: 2'b00, w: 1'b0, a: 32'h0, sz: 3'd0, wd: 32'h0};
        dp      = idle_op;
        for (int i = 0; i < MW; i++) ref_mem[i] = '0;

        // reset state
        HADDR = 32'h123;
        repeat (3) @(posedge HCLK);
        #2;
        chk("rst_ready", 32'(HREADYOUT), 32'd1);
        chk("rst_resp",  32'(HRESP), 32'd0);
        chk("rst_rdata", HRDATA, 32'h0);
        chk("rst_wea",   32'(BRAM_WEA), 32'd0);
        chk("rst_addrb", 32'(BRAM_ADDRB), 32'h48);
        @(posedge HCLK); #1;
        HRESETn = 1'b1; clr = 1'b0;

        // word write then read
        issue(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        issue(mk(1'b0, 32'h10, 3'd2, 32'h0));
        issue(idle_op);
        chk("word_rd", last_rd, 32'hDEADBEEF);

        // byte + halfword merge into word at 0x20
        issue(mk(1'b1, 32'h21, 3'd0, 32'h0000_1100));
        issue(mk(1'b1, 32'h22, 3'd1, 32'hAABB_0000));
        issue(mk(1'b0, 32'h20, 3'd2, 32'h0));
        issue(idle_op);
        chk("merge_rd", last_rd, 32'hAABB1100);

        // misaligned halfword write errors and leaves memory untouched
        issue(mk(1'b1, 32'h03, 3'd1, 32'hFFFF_FFFF));
        issue(mk(1'b0, 32'h00, 3'd2, 32'h0));
        issue(idle_op);
        chk("misal_rd", last_rd, 32'h0);

        // range boundary: first unpopulated word errors, last populated is fine
        issue(mk(1'b0, 32'h1000, 3'd2, 32'h0));
        issue(mk(1'b0, 32'h0FFC, 3'd2, 32'h0));
        issue(idle_op);

        // back-to-back write/read of the same word
        issue(mk(1'b1, 32'h30, 3'd2, 32'h12345678));
        issue(mk(1'b0, 32'h30, 3'd2, 32'h0));
        issue(idle_op);
        chk("b2b_rd", last_rd, 32'h12345678);

        // reset asserted during a write data phase
        issue(mk(1'b1, 32'h40, 3'd2, 32'h01020304));
        issue(mk(1'b1, 32'h40, 3'd2, 32'h55AA55AA));
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55AA55AA;
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_wea",   32'(BRAM_WEA), 32'd0);
        chk("mid_rst_ready", 32'(HREADYOUT), 32'd1);
        chk("mid_rst_resp",  32'(HRESP), 32'd0);
        chk("mid_rst_rdata", HRDATA, 32'h0);
        @(posedge HCLK); #2;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        dp = idle_op;
        issue(mk(1'b0, 32'h40, 3'd2, 32'h0));
        issue(idle_op);
        chk("rst_keep_rd", last_rd, 32'h01020304);

        // random traffic
        for (int n = 0; n < 600; n++) issue(rnd_op());
        issue(idle_op);
        issue(idle_op);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
